// File: rtl/divider_arbiter_if.sv
// Requester and divider signals of divider_arbiter; master = arbiter side, slave = requesters plus divider.
// Operand buses pack requester i at [16i+15:16i]; shift codes at [4i+3:4i].
interface divider_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [16*N-1:0] req_in0;
    logic [16*N-1:0] req_in1;
    logic [4*N-1:0]  req_shift;
    logic [N-1:0]    rsp_valid;
    logic [15:0]     rsp_data;
    logic            rsp_err;
    logic            div_once;
    logic [15:0]     div_in0;
    logic [15:0]     div_in1;
    logic [3:0]      div_shift;
    logic            div_done;
    logic [15:0]     div_out;

    modport master (
        input  req_valid, req_in0, req_in1, req_shift, div_done, div_out,
        output req_ready, rsp_valid, rsp_data, rsp_err, div_once, div_in0, div_in1, div_shift
    );

    modport slave (
        output req_valid, req_in0, req_in1, req_shift, div_done, div_out,
        input  req_ready, rsp_valid, rsp_data, rsp_err, div_once, div_in0, div_in1, div_shift
    );
endinterface

// File: rtl/divider_arbiter.sv
// Round-robin sharing of one iterative divider among N requesters; shift 0/15 resolved locally.
// Latency: passthrough accept+1, divider accept+2+L (optional WAIT abort with DIV_ARB_TIMEOUT_EN).
// Backpressure: one request in flight; req_ready is a one-hot strobe only while idle.
module divider_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 32
) (
    input  logic               clk,
    input  logic               rst,
    divider_arbiter_if.master  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state, state_nx;
    logic [IW-1:0]  last, id, gnt_idx, cand;
    logic           found, accept;
    logic [15:0]    sel_in0, sel_in1;
    logic [3:0]     sel_shift;
    logic [15:0]    op_in0, op_in1, result;
    logic [3:0]     op_shift;
    logic [N-1:0]   ready_oh, rsp_oh;

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0]  cnt;
    logic           timeout_hit;
    logic           err;

    assign timeout_hit = (state == WAIT) && (cnt == CW'(TIMEOUT - 1));
`else
    logic           unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    // First pending requester after the last grant, wrapping around.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!found && bus.req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign accept    = (state == IDLE) && found && !rst;
    assign sel_in0   = bus.req_in0[int'(gnt_idx)*16 +: 16];
    assign sel_in1   = bus.req_in1[int'(gnt_idx)*16 +: 16];
    assign sel_shift = bus.req_shift[int'(gnt_idx)*4 +: 4];

    always_comb begin
        state_nx = state;
        ready_oh = '0;
        rsp_oh   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    ready_oh[gnt_idx] = 1'b1;
                    state_nx = (sel_shift == 4'd0 || sel_shift == 4'd15) ? RESP : ISSUE;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (bus.div_done) begin
                    state_nx = RESP;
                end
`ifdef DIV_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_nx = RESP;
                end
`endif
            end
            RESP: begin
                rsp_oh[id] = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last     <= IW'(N - 1);
            id       <= '0;
            op_in0   <= '0;
            op_in1   <= '0;
            op_shift <= '0;
            result   <= '0;
`ifdef DIV_ARB_TIMEOUT_EN
            err      <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (accept) begin
                last     <= gnt_idx;
                id       <= gnt_idx;
                op_in0   <= sel_in0;
                op_in1   <= sel_in1;
                op_shift <= sel_shift;
`ifdef DIV_ARB_TIMEOUT_EN
                err      <= 1'b0;
`endif
                if (sel_shift == 4'd0) begin
                    result <= sel_in0;
                end else if (sel_shift == 4'd15) begin
                    result <= sel_in1;
                end
            end
            // A done coinciding with expiry takes precedence over the abort.
            if (state == WAIT) begin
                if (bus.div_done) begin
                    result <= bus.div_out;
                end
`ifdef DIV_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    result <= 16'hFFFF;
                    err    <= 1'b1;
                end
`endif
            end
        end
    end

`ifdef DIV_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state != WAIT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
    assign bus.rsp_err = err;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready = ready_oh;
    assign bus.rsp_valid = rsp_oh;
    assign bus.rsp_data  = result;
    assign bus.div_once  = (state == ISSUE);
    assign bus.div_in0   = op_in0;
    assign bus.div_in1   = op_in1;
    assign bus.div_shift = op_shift;
endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: directed cases plus random requesters against a transaction-level model.
// Inputs change after the rising edge; outputs are sampled 1 time unit after the falling edge.
module tb_divider_arbiter;
    localparam int N  = 4;
    localparam int L  = 6;
    localparam int TO = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    divider_arbiter_if #(.N(N)) bus ();

    divider_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] r_in0 [N];
    logic [15:0] r_in1 [N];
    logic [3:0]  r_shift [N];
    logic [N-1:0] r_vld;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          done_at = -1;
    int          rsp_cyc = -1;
    int          once_cyc = -1;
    int          gcyc = 0;
    int          once_cnt = 0;
    int          granted = -1;
    int          m_last = N - 1;
    int          m_id = 0;
    bit          busy = 1'b0;
    bit          fixed_en = 1'b0;
    bit          no_done = 1'b0;
    logic [15:0] fixed_val = 16'h0;
    logic [15:0] m_in0, m_in1, m_data, div_ret;
    logic [3:0]  m_shift;
    bit          m_err;
    int          glog [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] div_fn(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s);
        if (b == 16'h0) return 16'hFFFF;
        return 16'((32'(a) << s) / 32'(b));
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_in0[16*i +: 16] = r_in0[i];
            bus.req_in1[16*i +: 16] = r_in1[i];
            bus.req_shift[4*i +: 4] = r_shift[i];
        end
        bus.req_valid = r_vld;
    endtask

    // One clock: drive divider model, sample and check, update the transaction model.
    task automatic tick();
        int gnt;
        logic [N-1:0] exp_v;
        @(negedge clk);
        bus.div_done = (cyc == done_at);
        bus.div_out  = (cyc == done_at) ? div_ret : 16'($urandom);
        #1;
        gnt = -1;
        if (!rst && !busy) begin
            for (int k = 1; k <= N; k++) begin
                if (gnt < 0 && r_vld[(m_last + k) % N]) gnt = (m_last + k) % N;
            end
        end
        exp_v = (gnt >= 0) ? (N'(1) << gnt) : '0;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_v));
        exp_v = (busy && cyc == rsp_cyc) ? (N'(1) << m_id) : '0;
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
        if (busy && cyc == rsp_cyc) begin
            chk("rsp_data", 64'(bus.rsp_data), 64'(m_data));
            chk("rsp_err", 64'(bus.rsp_err), 64'(m_err));
        end
        chk("div_once", 64'(bus.div_once), 64'(busy && cyc == once_cyc));
        if (busy && cyc > gcyc) begin
            chk("div_in0_hold", 64'(bus.div_in0), 64'(m_in0));
            chk("div_shift_hold", 64'(bus.div_shift), 64'(m_shift));
        end
        if (bus.div_once === 1'b1) begin
            once_cnt++;
            chk("div_in1", 64'(bus.div_in1), 64'(m_in1));
            if (!no_done) done_at = cyc + L;
            div_ret = fixed_en ? fixed_val : div_fn(bus.div_in0, bus.div_in1, bus.div_shift);
        end
        if (busy && cyc == rsp_cyc) busy = 1'b0;
        granted = gnt;
        if (gnt >= 0) begin
            busy    = 1'b1;
            gcyc    = cyc;
            m_last  = gnt;
            m_id    = gnt;
            m_in0   = r_in0[gnt];
            m_in1   = r_in1[gnt];
            m_shift = r_shift[gnt];
            m_err   = 1'b0;
            glog.push_back(gnt);
            if (m_shift == 4'd0) begin
                m_data = m_in0; rsp_cyc = cyc + 1; once_cyc = -1;
            end else if (m_shift == 4'd15) begin
                m_data = m_in1; rsp_cyc = cyc + 1; once_cyc = -1;
            end else begin
                once_cyc = cyc + 1;
                m_data   = fixed_en ? fixed_val : div_fn(m_in0, m_in1, m_shift);
                rsp_cyc  = cyc + 2 + L;
`ifdef DIV_ARB_TIMEOUT_EN
                if (no_done) begin
                    m_data = 16'hFFFF; m_err = 1'b1; rsp_cyc = cyc + 2 + TO;
                end
`endif
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // mode 0: drop on grant; 1: keep requesting with shift 5; 2: random traffic
    task automatic advance(input int mode);
        for (int i = 0; i < N; i++) begin
            if (granted == i) begin
                if (mode == 0) r_vld[i] = 1'b0;
                else if (mode == 1) begin
                    r_in0[i] = 16'($urandom); r_in1[i] = 16'($urandom); r_shift[i] = 4'd5;
                end else begin
                    r_vld[i] = 1'($urandom_range(0, 1));
                    r_in0[i] = 16'($urandom); r_in1[i] = 16'($urandom);
                    r_shift[i] = ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) == 0) ? 4'd0 : 4'd15)
                                                             : 4'($urandom);
                end
            end else if (mode == 2) begin
                if (!r_vld[i] && $urandom_range(0, 3) == 0) begin
                    r_vld[i] = 1'b1;
                    r_in0[i] = 16'($urandom); r_in1[i] = 16'($urandom); r_shift[i] = 4'($urandom);
                end else if (r_vld[i] && $urandom_range(0, 31) == 0) begin
                    r_vld[i] = 1'b0;
                end else if (r_vld[i] && $urandom_range(0, 7) == 0) begin
                    r_in0[i] = 16'($urandom);
                end
            end
        end
        drive();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        busy = 1'b0;
        m_last = N - 1;
        r_vld = '0;
        drive();
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic run(input int n, input int mode);
        repeat (n) begin
            tick();
            advance(mode);
        end
    endtask

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            r_in0[i] = '0; r_in1[i] = '0; r_shift[i] = '0;
        end
        r_vld = '0;
        drive();
        bus.div_done = 1'b0;
        bus.div_out  = '0;
        do_reset(2);

        chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'h0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'h0);
        chk("rst_div_once", 64'(bus.div_once), 64'h0);
        chk("rst_div_in0", 64'(bus.div_in0), 64'h0);
        chk("rst_div_in1", 64'(bus.div_in1), 64'h0);
        chk("rst_div_shift", 64'(bus.div_shift), 64'h0);

        // Passthrough codes
        r_in0[0] = 16'h1234; r_in1[0] = 16'h5555; r_shift[0] = 4'd0; r_vld[0] = 1'b1; drive();
        tick(); chk("t1_grant", 64'(granted), 64'd0); advance(0);
        run(3, 0);
        r_in0[2] = 16'h7777; r_in1[2] = 16'hBEEF; r_shift[2] = 4'd15; r_vld[2] = 1'b1; drive();
        tick(); chk("t2_grant", 64'(granted), 64'd2); advance(0);
        run(3, 0);
        chk("t2_no_once", 64'(once_cnt), 64'd0);

        // Divider path with fixed divider result
        fixed_en = 1'b1; fixed_val = 16'h0ABC;
        r_in0[1] = 16'h4000; r_in1[1] = 16'h0003; r_shift[1] = 4'd3; r_vld[1] = 1'b1; drive();
        tick(); chk("t3_grant", 64'(granted), 64'd1); advance(0);
        run(12, 0);
        chk("t3_once_cnt", 64'(once_cnt), 64'd1);
        fixed_en = 1'b0;

        // Round-robin with all four held
        do_reset(1);
        glog.delete();
        for (int i = 0; i < N; i++) begin
            r_in0[i] = 16'($urandom); r_in1[i] = 16'($urandom); r_shift[i] = 4'd5;
        end
        r_vld = '1; drive();
        for (int t = 0; t < 200 && glog.size() < 5; t++) run(1, 1);
        chk("t4_grants", 64'(glog.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < glog.size()) chk($sformatf("t4_order%0d", i), 64'(glog[i]), 64'(exp_order[i]));
        end
        r_vld = '0; drive();
        run(12, 0);

        // Reset while waiting on the divider, then a stray done
        do_reset(1);
        r_in0[2] = 16'h9999; r_in1[2] = 16'h0011; r_shift[2] = 4'd5; r_vld[2] = 1'b1; drive();
        tick(); chk("t5_first", 64'(granted), 64'd2); advance(0);
        run(3, 0);
        do_reset(1);
        run(8, 0);
        r_in0[3] = 16'h0303; r_in1[3] = 16'h0003; r_shift[3] = 4'd0; r_vld[3] = 1'b1;
        r_in0[0] = 16'h0101; r_in1[0] = 16'h0001; r_shift[0] = 4'd0; r_vld[0] = 1'b1; drive();
        tick(); chk("t5_after_rst", 64'(granted), 64'd0); advance(0);
        run(8, 0);

`ifdef DIV_ARB_TIMEOUT_EN
        do_reset(1);
        no_done = 1'b1;
        r_in0[1] = 16'h1111; r_in1[1] = 16'h0002; r_shift[1] = 4'd7; r_vld[1] = 1'b1; drive();
        tick(); chk("t6_grant", 64'(granted), 64'd1); advance(0);
        run(40, 0);
        no_done = 1'b0;
        done_at = -1;
`endif

        // Random traffic
        do_reset(1);
        run(3000, 2);
        r_vld = '0; drive();
        run(40, 0);
        chk("drained", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
